// File: rtl/proc_monitor_pkg.sv
// Shared types and helpers for the processor run monitor.
//   state_e  : monitor FSM encoding (HOLD -> RUN -> CHECK -> DONE)
//   sat_inc  : saturating increment. Operands are 32 bits, so counters up to 32 bits wide are supported.
package proc_monitor_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Returns val+1, or val unchanged once it has reached max_val.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/proc_run_monitor_if.sv
// Register-file writeback snoop bus (ctrl_writeEnable / ctrl_writeReg / data_writeReg).
//   master : the core side or the bench, which drives the bus
//   slave  : the monitor, which only observes
interface proc_run_monitor_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DATA_W     = 32
);
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0]     wb_data;

    modport master (output wb_en, output wb_reg, output wb_data);
    modport slave  (input  wb_en, input  wb_reg, input  wb_data);
endinterface

// File: rtl/proc_monitor_shadow_rf.sv
// Shadow copy of the processor register file.
// Ports:
//   clock, reset : rising-edge clock; synchronous active-high clear of every entry
//   we/waddr/wdata : single write port. Writes to entry 0 are dropped, so r0 always reads 0.
//   raddr/rdata  : combinational read port
module proc_monitor_shadow_rf #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: clear all entries on reset; r0 is never written.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/proc_run_monitor.sv
// Run controller and checker for the processor skeleton.
// The monitor holds the core in reset, counts the run cycles and shadows the writeback port.
// When the core halts or the cycle budget runs out, the monitor checks the shadow against an
// expected table, one entry per cycle, and then reports done and pass.
// Ports:
//   clock, reset         : sole clock; synchronous active-high reset
//   halt                 : end-of-program indication
//   wb (slave)           : writeback snoop bus, carrying wb_en, wb_reg and wb_data
//   exp_reg / exp_data   : flattened expected table. Entry i sits at [i*W +: W].
//   core_reset           : reset to the processor
//   running / done       : high in RUN / DONE
//   pass / timeout       : verdict, valid when done; timeout means the budget expired
//   cycle_count          : RUN cycles elapsed (saturating)
//   error_count          : table mismatches (saturating)
//   first_fail_*         : first mismatch trace
// Build option: define PROC_RUN_MONITOR_TRACE_EN to enable the first_fail_* capture.
// Without it, those outputs are tied to 0.
module proc_run_monitor
    import proc_monitor_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 200,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned NUM_CHECKS   = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             halt,
    proc_run_monitor_if.slave                wb,
    input  logic [NUM_CHECKS*REG_ADDR_W-1:0] exp_reg,
    input  logic [NUM_CHECKS*DATA_W-1:0]     exp_data,
    output logic                             core_reset,
    output logic                             running,
    output logic                             done,
    output logic                             pass,
    output logic                             timeout,
    output logic [CNT_W-1:0]                 cycle_count,
    output logic [CNT_W-1:0]                 error_count,
    output logic                             first_fail_vld,
    output logic [REG_ADDR_W-1:0]            first_fail_reg,
    output logic [DATA_W-1:0]                first_fail_data
);

    localparam int unsigned IDX_W  = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e                state, state_nxt;
    logic [HOLD_W-1:0]     hold_cnt, hold_cnt_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [CNT_W-1:0]      cycle_nxt, err_nxt;
    logic                  timeout_nxt, pass_nxt;
    logic                  shadow_we;
    logic [REG_ADDR_W-1:0] chk_reg;
    logic [DATA_W-1:0]     chk_data, rd_data;
    logic                  mismatch;

    proc_monitor_shadow_rf #(
        .ADDR_W (REG_ADDR_W),
        .DATA_W (DATA_W)
    ) u_shadow (
        .clock (clock),
        .reset (reset),
        .we    (shadow_we),
        .waddr (wb.wb_reg),
        .wdata (wb.wb_data),
        .raddr (chk_reg),
        .rdata (rd_data)
    );

    // Next-state, counter and verdict logic.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        idx_nxt      = idx;
        cycle_nxt    = cycle_count;
        err_nxt      = error_count;
        timeout_nxt  = timeout;
        pass_nxt     = pass;
        shadow_we    = 1'b0;
        chk_reg      = exp_reg[idx*REG_ADDR_W +: REG_ADDR_W];
        chk_data     = exp_data[idx*DATA_W +: DATA_W];
        mismatch     = (rd_data != chk_data);

        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_nxt = ST_RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                shadow_we = wb.wb_en;
                cycle_nxt = CNT_W'(sat_inc(32'(cycle_count), 32'(CNT_MAX)));
                // Halt takes priority over budget expiry in the same cycle.
                if (halt) begin
                    state_nxt   = ST_CHECK;
                    timeout_nxt = 1'b0;
                    idx_nxt     = '0;
                end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
                    state_nxt   = ST_CHECK;
                    timeout_nxt = 1'b1;
                    idx_nxt     = '0;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_nxt = CNT_W'(sat_inc(32'(error_count), 32'(CNT_MAX)));
                end
                if (idx == IDX_W'(NUM_CHECKS - 1)) begin
                    state_nxt = ST_DONE;
                    pass_nxt  = (err_nxt == '0) && !timeout;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            ST_DONE: begin
            end
            default: state_nxt = ST_HOLD;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_HOLD;
            hold_cnt    <= '0;
            idx         <= '0;
            cycle_count <= '0;
            error_count <= '0;
            timeout     <= 1'b0;
            pass        <= 1'b0;
            core_reset  <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_cnt_nxt;
            idx         <= idx_nxt;
            cycle_count <= cycle_nxt;
            error_count <= err_nxt;
            timeout     <= timeout_nxt;
            pass        <= pass_nxt;
            core_reset  <= (state_nxt == ST_HOLD);
            running     <= (state_nxt == ST_RUN);
            done        <= (state_nxt == ST_DONE);
        end
    end

`ifdef PROC_RUN_MONITOR_TRACE_EN
    // Capture the first mismatch only; later ones leave the trace untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            first_fail_vld  <= 1'b0;
            first_fail_reg  <= '0;
            first_fail_data <= '0;
        end else if ((state == ST_CHECK) && mismatch && !first_fail_vld) begin
            first_fail_vld  <= 1'b1;
            first_fail_reg  <= chk_reg;
            first_fail_data <= rd_data;
        end
    end
`else
    assign first_fail_vld  = 1'b0;
    assign first_fail_reg  = '0;
    assign first_fail_data = '0;
`endif

endmodule

// File: tb/tb_proc_run_monitor.sv
// Randomised self-checking bench for proc_run_monitor.
// The reference is a plain "last write wins" register array.
// Expected verdicts are derived from that array and the expected table.
module tb_proc_run_monitor;

    localparam int unsigned RESET_CYCLES = 2;
    localparam int unsigned MAX_CYCLES   = 200;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned NUM_CHECKS   = 4;
    localparam int unsigned CNT_W        = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                             reset;
    logic                             halt;
    logic [NUM_CHECKS*REG_ADDR_W-1:0] exp_reg;
    logic [NUM_CHECKS*DATA_W-1:0]     exp_data;
    logic                             core_reset, running, done, pass, timeout;
    logic [CNT_W-1:0]                 cycle_count, error_count;
    logic                             first_fail_vld;
    logic [REG_ADDR_W-1:0]            first_fail_reg;
    logic [DATA_W-1:0]                first_fail_data;

    proc_run_monitor_if #(.REG_ADDR_W(REG_ADDR_W), .DATA_W(DATA_W)) wb_bus ();

    proc_run_monitor #(
        .RESET_CYCLES (RESET_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .DATA_W       (DATA_W),
        .REG_ADDR_W   (REG_ADDR_W),
        .NUM_CHECKS   (NUM_CHECKS),
        .CNT_W        (CNT_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .halt            (halt),
        .wb              (wb_bus),
        .exp_reg         (exp_reg),
        .exp_data        (exp_data),
        .core_reset      (core_reset),
        .running         (running),
        .done            (done),
        .pass            (pass),
        .timeout         (timeout),
        .cycle_count     (cycle_count),
        .error_count     (error_count),
        .first_fail_vld  (first_fail_vld),
        .first_fail_reg  (first_fail_reg),
        .first_fail_data (first_fail_data)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Program: per RUN cycle writeback stimulus, plus the cycle on which halt is raised (-1 = never).
    bit                    p_en   [MAX_CYCLES];
    logic [REG_ADDR_W-1:0] p_reg  [MAX_CYCLES];
    logic [DATA_W-1:0]     p_data [MAX_CYCLES];
    int                    halt_at;
    logic [REG_ADDR_W-1:0] t_reg  [NUM_CHECKS];
    logic [DATA_W-1:0]     t_data [NUM_CHECKS];
    logic [DATA_W-1:0]     model  [2**REG_ADDR_W];

    task automatic clear_prog();
        for (int c = 0; c < int'(MAX_CYCLES); c++) begin
            p_en[c] = 1'b0; p_reg[c] = '0; p_data[c] = '0;
        end
        halt_at = -1;
    endtask

    task automatic set_wr(input int c, input int r, input logic [DATA_W-1:0] d);
        p_en[c] = 1'b1; p_reg[c] = REG_ADDR_W'(r); p_data[c] = d;
    endtask

    task automatic set_tab(input int i, input int r, input logic [DATA_W-1:0] d);
        t_reg[i] = REG_ADDR_W'(r); t_data[i] = d;
    endtask

    // The run ends on the halt cycle, or else on the last budget cycle.
    function automatic int end_cycle();
        return (halt_at >= 0 && halt_at < int'(MAX_CYCLES)) ? halt_at : int'(MAX_CYCLES) - 1;
    endfunction

    // Final register state: last non-r0 write up to and including the end cycle.
    task automatic compute_model();
        for (int r = 0; r < 2**REG_ADDR_W; r++) model[r] = '0;
        for (int c = 0; c <= end_cycle(); c++)
            if (p_en[c] && p_reg[c] != '0) model[p_reg[c]] = p_data[c];
    endtask

    task automatic load_table();
        for (int i = 0; i < int'(NUM_CHECKS); i++) begin
            exp_reg[i*REG_ADDR_W +: REG_ADDR_W] = t_reg[i];
            exp_data[i*DATA_W +: DATA_W]        = t_data[i];
        end
    endtask

    task automatic bus_idle();
        wb_bus.wb_en = 1'b0; wb_bus.wb_reg = '0; wb_bus.wb_data = '0; halt = 1'b0;
    endtask

    // Release reset and measure how long core_reset stays high. The task ends in RUN cycle 0.
    task automatic release_reset();
        int hold;
        @(posedge clock); #1 reset = 1'b0;
        hold = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (core_reset) hold++;
            else break;
        end
        check("core_reset_len", 64'(hold), 64'(RESET_CYCLES));
        check("run_entry_running", 64'(running), 64'd1);
        check("run_entry_count", 64'(cycle_count), 64'd0);
    endtask

    task automatic start_run();
        bus_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_outputs", 64'({running, done, pass, timeout}), 64'd0);
        check("rst_counts", 64'({cycle_count, error_count}), 64'd0);
        check("rst_trace", 64'({first_fail_vld, first_fail_reg, first_fail_data}), 64'd0);
        release_reset();
    endtask

    // Apply the program cycle by cycle. The task returns in CHECK idx 0.
    task automatic run_body(output bit exp_to);
        int ec;
        ec = end_cycle();
        exp_to = !(halt_at >= 0 && halt_at < int'(MAX_CYCLES));
        for (int t = 0; t <= ec; t++) begin
            check("run_running", 64'(running), 64'd1);
            check("run_count", 64'(cycle_count), 64'(t));
            wb_bus.wb_en   = p_en[t];
            wb_bus.wb_reg  = p_reg[t];
            wb_bus.wb_data = p_data[t];
            halt           = (t == halt_at);
            @(posedge clock); @(negedge clock);
        end
        bus_idle();
        check("chk_running", 64'(running), 64'd0);
        check("chk_count", 64'(cycle_count), 64'(ec + 1));
    endtask

    // Drive noise on the bus during CHECK/DONE. The verdict must still follow the model.
    task automatic check_phase(input bit exp_to);
        int                    lat, exp_err;
        bit                    found;
        logic [REG_ADDR_W-1:0] ff_reg;
        logic [DATA_W-1:0]     ff_data;
        logic                  pass_seen;
        exp_err = 0; found = 1'b0; ff_reg = '0; ff_data = '0;
        for (int i = 0; i < int'(NUM_CHECKS); i++) begin
            if (model[t_reg[i]] != t_data[i]) begin
                exp_err++;
                if (!found) begin found = 1'b1; ff_reg = t_reg[i]; ff_data = model[t_reg[i]]; end
            end
        end
        lat = 0;
        while (!done && lat < int'(NUM_CHECKS) + 8) begin
            wb_bus.wb_en   = 1'b1;
            wb_bus.wb_reg  = REG_ADDR_W'($urandom_range(0, 2**REG_ADDR_W - 1));
            wb_bus.wb_data = $urandom;
            halt           = 1'($urandom_range(0, 1));
            @(posedge clock); @(negedge clock);
            lat++;
        end
        bus_idle();
        check("check_latency", 64'(lat), 64'(NUM_CHECKS));
        check("done", 64'(done), 64'd1);
        check("error_count", 64'(error_count), 64'(exp_err));
        check("timeout", 64'(timeout), 64'(exp_to));
        check("pass", 64'(pass), 64'((exp_err == 0) && !exp_to));
`ifdef PROC_RUN_MONITOR_TRACE_EN
        check("trace_vld", 64'(first_fail_vld), 64'(found));
        if (found) begin
            check("trace_reg", 64'(first_fail_reg), 64'(ff_reg));
            check("trace_data", 64'(first_fail_data), 64'(ff_data));
        end
`else
        check("trace_off", 64'({first_fail_vld, first_fail_reg, first_fail_data}), 64'd0);
`endif
        pass_seen = pass;
        halt = 1'b1;
        repeat (3) begin
            @(posedge clock); @(negedge clock);
            check("done_hold", 64'({done, pass, running, core_reset}), 64'({1'b1, pass_seen, 2'b00}));
        end
        halt = 1'b0;
    endtask

    task automatic run_case();
        bit exp_to;
        compute_model();
        load_table();
        start_run();
        run_body(exp_to);
        check_phase(exp_to);
    endtask

    initial begin
        bit dummy_to;
        reset = 1'b1;
        exp_reg = '0; exp_data = '0;
        bus_idle();

        // Clean run that should pass.
        clear_prog();
        set_wr(0, 1, 32'd5); set_wr(1, 2, 32'd7); halt_at = 2;
        set_tab(0, 1, 32'd5); set_tab(1, 2, 32'd7); set_tab(2, 0, 32'd0); set_tab(3, 1, 32'd5);
        run_case();

        // A single mismatch on r3.
        clear_prog();
        set_wr(0, 3, 32'd9); halt_at = 1;
        set_tab(0, 3, 32'd10); set_tab(1, 0, 32'd0); set_tab(2, 0, 32'd0); set_tab(3, 3, 32'd9);
        run_case();

        // Budget expiry with a table that matches.
        clear_prog();
        set_wr(5, 6, 32'h1234);
        set_tab(0, 6, 32'h1234); set_tab(1, 0, 32'd0); set_tab(2, 7, 32'd0); set_tab(3, 6, 32'h1234);
        run_case();

        // r0 is dropped, last write wins, and the halt-cycle write is still captured.
        clear_prog();
        set_wr(0, 0, 32'hFFFF_FFFF); set_wr(1, 4, 32'd1); set_wr(2, 4, 32'd2); set_wr(3, 5, 32'd3);
        halt_at = 3;
        set_tab(0, 0, 32'd0); set_tab(1, 4, 32'd2); set_tab(2, 5, 32'd3); set_tab(3, 0, 32'd0);
        run_case();

        // Halt on the last budget cycle wins over timeout.
        clear_prog();
        set_wr(199, 8, 32'hAB); halt_at = 199;
        set_tab(0, 8, 32'hAB); set_tab(1, 0, 32'd0); set_tab(2, 8, 32'hAB); set_tab(3, 1, 32'd0);
        run_case();

        // Reset in CHECK idx 2, then a rerun must see a cleared shadow.
        clear_prog();
        set_wr(0, 1, 32'h55); halt_at = 2;
        set_tab(0, 1, 32'd0); set_tab(1, 1, 32'd0); set_tab(2, 1, 32'd0); set_tab(3, 1, 32'd0);
        compute_model(); load_table(); start_run();
        run_body(dummy_to);
        repeat (2) begin @(posedge clock); @(negedge clock); end
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        check("midchk_rst_done", 64'(done), 64'd0);
        check("midchk_rst_err", 64'(error_count), 64'd0);
        check("midchk_rst_core", 64'(core_reset), 64'd1);
        release_reset();
        clear_prog(); halt_at = 3;
        compute_model();
        run_body(dummy_to);
        check_phase(dummy_to);

        // Random programs and tables.
        for (int n = 0; n < 24; n++) begin
            clear_prog();
            halt_at = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 40));
            for (int c = 0; c <= end_cycle() && c < 60; c++) begin
                p_en[c]   = 1'($urandom_range(0, 1));
                p_reg[c]  = REG_ADDR_W'($urandom_range(0, 7));
                p_data[c] = ($urandom_range(0, 1) == 0) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
            end
            compute_model();
            for (int i = 0; i < int'(NUM_CHECKS); i++) begin
                t_reg[i]  = REG_ADDR_W'($urandom_range(0, 7));
                t_data[i] = model[t_reg[i]];
                if ($urandom_range(0, 2) == 0) t_data[i] = t_data[i] ^ (32'd1 << $urandom_range(0, 31));
            end
            run_case();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
